regfile_bypass: RTL
===================

Name: regfile_bypass

Overview:
- 32 x 64-bit integer register file for the 5-stage pipeline.
- Written by the WB stage; read combinationally by the ID stage through two independent read ports.
- Storage is flip-flop based, built from enable-gated register words.
- A same-cycle write-to-read bypass lets ID see the value WB is writing in that cycle, so the WB->ID hazard needs no stall.
- Register 31 is hardwired zero (XZR).

Parameters:
- DATA_W, 64, width of each register and of the data ports.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register-address width; must equal clog2(NUM_REGS).
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears every register.
- wr_en  in  1  write enable from WB.
- wr_addr  in  ADDR_W  destination register.
- wr_data  in  DATA_W  value to write.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Storage: regs[0..NUM_REGS-1], each DATA_W bits.
- Reset: at any posedge with reset=1, all regs load 0 and any write that cycle is discarded. After that edge every read returns 0.
- Write: at a posedge with reset=0, wr_en=1 and wr_addr!=ZERO_REG, regs[wr_addr] <= wr_data.
  - All other registers hold their value.
  - A write to ZERO_REG is a no-op.
- Read, per port n, evaluated in priority order:
  - rd_addrn==ZERO_REG -> 0.
  - Else if wr_en=1, reset=0 and wr_addr==rd_addrn -> wr_data (write-first bypass, zero latency).
  - Else -> regs[rd_addrn].
- Latency:
  - Read without bypass: 0 cycles (combinational).
  - Write: visible through the bypass in the same cycle, and from storage from the next cycle onward.
- Both ports may address the same register; both return the identical value, bypass included.
- While reset=1, the bypass is suppressed and reads return stored values. Those values are 0 from the first posedge of reset onward.
- Reset asserted mid-program, e.g. during a pipeline flush: takes effect at the next posedge only. Reads in the same cycle still reflect pre-reset storage, without bypass.
- Before the first reset edge, register contents are X; the bench must not check them.
- No X propagation from an unused port: an address that is X only affects its own port.
- Out-of-range addresses cannot occur, since NUM_REGS = 2^ADDR_W.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W, ADDR_W, NUM_REGS, ZERO_REG constants.
  - typedef word_t = logic [DATA_W-1:0].
  - typedef regaddr_t = logic [ADDR_W-1:0].
- One natural sub-module, en_reg_word:
  - DATA_W-wide register with clk, reset (synchronous, active-high, clears to 0), en, d, q.
  - Instantiated NUM_REGS-1 times; no storage for ZERO_REG.
- Top level contains:
  - the 5-to-32 write-enable decoder (one-hot, gated by wr_en);
  - two 32:1 read muxes;
  - the bypass/zero logic.

Test Plan:
- Reset, then wr_en=0, reads of every address on both ports -> all 0 on rd_data1 and rd_data2.
- Write X5=0x0000_0000_DEAD_BEEF; next cycle rd_addr1=5, rd_addr2=4 -> rd_data1=0xDEADBEEF, rd_data2=0.
- Bypass: same cycle wr_en=1, wr_addr=7, wr_data=0x1234, rd_addr1=rd_addr2=7 -> both ports 0x1234 before the edge; after the edge, with wr_en=0, both still 0x1234.
- Zero register: write X31=0xFFFF_FFFF_FFFF_FFFF with rd_addr1=31 -> rd_data1=0 in that cycle and every later cycle.
- Write-then-reset: write X9=0xAA; in the next cycle assert reset with wr_en=1, wr_addr=9, wr_data=0x55, rd_addr1=9 -> rd_data1=0xAA (no bypass) during that cycle, then X9=0 after the edge (write discarded).
- Sweep: write regs 0..30 with value (i<<32)|i, then read all pairs (i, 30-i) -> each port returns its own index's pattern; no aliasing between registers.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int ZERO_REG = 31;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/regfile_bypass_if.sv
// Write port (from WB) and two read ports (to ID) of the register file.
// Latency: n/a (signal bundle only).
// Backpressure: none; writes and reads are accepted every cycle.
interface regfile_bypass_if;
  import regfile_pkg::*;

  logic     wr_en;
  regaddr_t wr_addr;
  word_t    wr_data;
  regaddr_t rd_addr1;
  regaddr_t rd_addr2;
  word_t    rd_data1;
  word_t    rd_data2;

  // Pipeline side: issues writes and read addresses, consumes read data.
  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2
  );

  // Register file side.
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2
  );
endinterface

// File: rtl/regfile_bypass_en_reg_word.sv
// One enable-gated register word with synchronous clear.
// Latency: d appears on q one cycle after an enabled edge.
// Backpressure: none; en is a plain load strobe.
module en_reg_word
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  word_t d,
  output word_t q
);

  // Clear has priority so a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_bypass.sv
// 32 x 64-bit register file, two combinational read ports, write-first bypass, X31 reads zero.
// Latency: reads 0 cycles; a write is visible via bypass the same cycle, from storage the next.
// Backpressure: none; one write and two reads are serviced every cycle.
module regfile_bypass
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  regfile_bypass_if.slave  rf
);

  logic [NUM_REGS-1:0] wr_sel;
  word_t               q [NUM_REGS];

  // One-hot write decoder; the zero register never gets an enable.
  always_comb begin
    wr_sel = '0;
    if (rf.wr_en) begin
      wr_sel[rf.wr_addr] = 1'b1;
    end
    wr_sel[ZERO_REG] = 1'b0;
  end

  // Storage for every register except the hardwired zero.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
    if (i == ZERO_REG) begin : g_zero
      assign q[i] = '0;
    end else begin : g_store
      en_reg_word u_word (
        .clk   (clk),
        .reset (reset),
        .en    (wr_sel[i]),
        .d     (rf.wr_data),
        .q     (q[i])
      );
    end
  end

  // Port 1: zero register first, then same-cycle bypass (suppressed in reset), then storage.
  always_comb begin
    rf.rd_data1 = q[rf.rd_addr1];
    if (rf.rd_addr1 == regaddr_t'(ZERO_REG)) begin
      rf.rd_data1 = '0;
    end else if (rf.wr_en && !reset && (rf.wr_addr == rf.rd_addr1)) begin
      rf.rd_data1 = rf.wr_data;
    end
  end

  // Port 2: same priority as port 1, fully independent of port 1's address.
  always_comb begin
    rf.rd_data2 = q[rf.rd_addr2];
    if (rf.rd_addr2 == regaddr_t'(ZERO_REG)) begin
      rf.rd_data2 = '0;
    end else if (rf.wr_en && !reset && (rf.wr_addr == rf.rd_addr2)) begin
      rf.rd_data2 = rf.wr_data;
    end
  end

endmodule
